main_fsm: RTL and testbench

//  Multicycle RV32I control FSM. Sequences each instruction through fetch, decode, execute, memory and writeback.

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/main_fsm_if.sv | 29 ++
 rtl/main_fsm.sv | 186 ++++++++++++++++++
 tb/tb_main_fsm.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the multicycle RV32I control FSM: opcodes, the state
// encoding and the datapath mux select encodings.
package riscv_pkg;

   // Opcode field values (instr[6:0]) recognised by the controller
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALU operation class handed to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BEQ,
      S_JAL
   } state_t;

   // States that stall on the memory handshake and are covered by the watchdog
   function automatic logic is_wait_state(state_t s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
interface main_fsm_if;
   logic [6:0] op;
   logic       mem_ready;
   logic       pc_update;
   logic       branch;
   logic       ir_write;
   logic       reg_write;
   logic       mem_write;
   logic       adr_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] alu_op;
   logic       illegal_op;
   logic       mem_timeout;

   modport master (
      input  op, mem_ready,
      output pc_update, branch, ir_write, reg_write, mem_write, adr_src,
             alu_src_a, alu_src_b, result_src, alu_op, illegal_op, mem_timeout
   );

   modport slave (
      output op, mem_ready,
      input  pc_update, branch, ir_write, reg_write, mem_write, adr_src,
             alu_src_a, alu_src_b, result_src, alu_op, illegal_op, mem_timeout
   );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM with memory wait handshake and a watchdog that
// aborts back to FETCH when memory stalls for too long.
module main_fsm
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255   // 0 disables the watchdog
) (
   input  logic       clk,
   input  logic       rst,
   main_fsm_if.master bus
);

   // Counter just wide enough to hold TIMEOUT_CYCLES; saturates at all-ones.
   localparam int unsigned CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int unsigned LAST_I  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CW-1:0] CNT_LAST = LAST_I[CW-1:0];
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic       waiting, timeout_hit;
   logic       pc_update, branch, ir_write, reg_write, mem_write, adr_src;
   logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
   logic       illegal_op, mem_timeout;

   // State register and watchdog counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, watchdog and control output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_update   = 1'b0;
      branch      = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RD2;
      result_src  = RES_ALUOUT;
      alu_op      = ALUOP_ADD;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;

      waiting     = is_wait_state(state_q) && !bus.mem_ready;
      // A ready in the same cycle always beats the watchdog (waiting is 0 then)
      timeout_hit = waiting && (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

      case (state_q)
         S_FETCH: begin
            adr_src    = 1'b0;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALURESULT;
            ir_write   = bus.mem_ready;
            pc_update  = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            // Precompute the branch target OldPC + imm while decoding
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ADD;
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ADD;
            state_d   = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
            if (bus.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            // Write request is held until memory accepts it
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
            mem_write  = 1'b1;
            if (bus.mem_ready) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_RD2;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECUTEI: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_BEQ: begin
            // Target comes from ALUOut (computed in DECODE), compare via subtract
            alu_src_a  = SRCA_RD1;
            alu_src_b  = SRCB_RD2;
            alu_op     = ALUOP_SUB;
            result_src = RES_ALUOUT;
            branch     = 1'b1;
            state_d    = S_FETCH;
         end
         S_JAL: begin
            // PC <- target from ALUOut; ALU forms OldPC+4 for the link register
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALUOUT;
            pc_update  = 1'b1;
            state_d    = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase

      // Watchdog abort overrides the normal stay-in-state decision
      if (timeout_hit) begin
         mem_timeout = 1'b1;
         state_d     = S_FETCH;
      end

      if (timeout_hit || !waiting || (state_d != state_q)) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      // Reset suppresses every side effect; selects are harmless and left alone
      if (rst) begin
         pc_update   = 1'b0;
         branch      = 1'b0;
         ir_write    = 1'b0;
         reg_write   = 1'b0;
         mem_write   = 1'b0;
         illegal_op  = 1'b0;
         mem_timeout = 1'b0;
      end
   end

   assign bus.pc_update   = pc_update;
   assign bus.branch      = branch;
   assign bus.ir_write    = ir_write;
   assign bus.reg_write   = reg_write;
   assign bus.mem_write   = mem_write;
   assign bus.adr_src     = adr_src;
   assign bus.alu_src_a   = alu_src_a;
   assign bus.alu_src_b   = alu_src_b;
   assign bus.result_src  = result_src;
   assign bus.alu_op      = alu_op;
   assign bus.illegal_op  = illegal_op;
   assign bus.mem_timeout = mem_timeout;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: instruction-level reference model that scripts the
// expected control vector for every cycle of every instruction.
module tb_main_fsm;
   import riscv_pkg::*;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   main_fsm_if bus();

   main_fsm #(.TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   // Control vector: {pcu,br,irw,rw,mw,adr,a[2],b[2],res[2],aop[2],ill,tmo}
   localparam logic [15:0] E_PCU = 16'h8000;
   localparam logic [15:0] E_BR  = 16'h4000;
   localparam logic [15:0] E_IRW = 16'h2000;
   localparam logic [15:0] E_RW  = 16'h1000;
   localparam logic [15:0] E_MW  = 16'h0800;
   localparam logic [15:0] E_ADR = 16'h0400;
   localparam logic [15:0] E_ILL = 16'h0002;
   localparam logic [15:0] E_TMO = 16'h0001;

   function automatic logic [15:0] sel(logic [1:0] a, logic [1:0] b, logic [1:0] res, logic [1:0] aop);
      return {6'b0, a, b, res, aop, 2'b00};
   endfunction

   localparam logic [15:0] V_F   = sel(2'b00, 2'b10, 2'b10, 2'b00);
   localparam logic [15:0] V_D   = sel(2'b01, 2'b01, 2'b00, 2'b00);
   localparam logic [15:0] V_MA  = sel(2'b10, 2'b01, 2'b00, 2'b00);
   localparam logic [15:0] V_MR  = E_ADR;
   localparam logic [15:0] V_MWB = E_RW | sel(2'b00, 2'b00, 2'b01, 2'b00);
   localparam logic [15:0] V_MW  = E_ADR | E_MW;
   localparam logic [15:0] V_EXR = sel(2'b10, 2'b00, 2'b00, 2'b10);
   localparam logic [15:0] V_EXI = sel(2'b10, 2'b01, 2'b00, 2'b10);
   localparam logic [15:0] V_AWB = E_RW;
   localparam logic [15:0] V_BEQ = E_BR | sel(2'b10, 2'b00, 2'b00, 2'b01);
   localparam logic [15:0] V_JAL = E_PCU | sel(2'b01, 2'b10, 2'b00, 2'b00);
   localparam logic [15:0] ENABLES = E_PCU | E_BR | E_IRW | E_RW | E_MW | E_ILL | E_TMO;

   function automatic logic [15:0] observed();
      return {bus.pc_update, bus.branch, bus.ir_write, bus.reg_write, bus.mem_write,
              bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_op,
              bus.illegal_op, bus.mem_timeout};
   endfunction

   function automatic bit is_legal(logic [6:0] op);
      return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: drive mem_ready, let outputs settle, compare, advance past the edge
   task automatic cyc(input string tag, input logic rdy, input logic [15:0] exp);
      bus.mem_ready = rdy;
      #1;
      check(tag, observed(), exp);
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_any(input string tag, input logic [15:0] exp);
      logic r;
      r = 1'($urandom_range(0, 1));
      cyc(tag, r, exp);
   endtask

   // A memory-stalled phase: 'waits' idle cycles then ready, unless the
   // watchdog fires first on the TO-th consecutive idle cycle.
   task automatic wait_phase(input string tag, input logic [15:0] base,
                             input logic [15:0] on_ready, input int waits, output bit ok);
      ok = 1'b0;
      for (int i = 0; i <= waits; i++) begin
         if (i == waits) begin
            cyc(tag, 1'b1, on_ready);
            ok = 1'b1;
            return;
         end
         if (i == TO - 1) begin
            cyc({tag, "_timeout"}, 1'b0, base | E_TMO);
            return;
         end
         cyc(tag, 1'b0, base);
      end
   endtask

   // Runs one instruction from FETCH back to the start of the next FETCH
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
      bit ok;
      bus.op = op;
      wait_phase("fetch", V_F, V_F | E_PCU | E_IRW, fw, ok);
      if (!ok) return;
      if (!is_legal(op)) begin
         cyc_any("decode_illegal", V_D | E_ILL);
         return;
      end
      cyc_any("decode", V_D);
      case (op)
         OP_LW: begin
            cyc_any("memadr_lw", V_MA);
            wait_phase("memread", V_MR, V_MR, mw, ok);
            if (ok) cyc_any("memwb", V_MWB);
         end
         OP_SW: begin
            cyc_any("memadr_sw", V_MA);
            wait_phase("memwrite", V_MW, V_MW, mw, ok);
         end
         OP_R: begin
            cyc_any("executer", V_EXR);
            cyc_any("aluwb_r", V_AWB);
         end
         OP_I: begin
            cyc_any("executei", V_EXI);
            cyc_any("aluwb_i", V_AWB);
         end
         OP_BEQ: cyc_any("beq", V_BEQ);
         OP_JAL: begin
            cyc_any("jal", V_JAL);
            cyc_any("aluwb_jal", V_AWB);
         end
         default: ;
      endcase
   endtask

   function automatic int pick_waits();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) return 0;
      if (r < 8) return int'($urandom_range(1, 3));
      return int'($urandom_range(4, 6));
   endfunction

   initial begin
      logic [6:0] legal_ops [6];
      logic [31:0] rnd;
      logic [6:0]  op;
      legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

      // Reset: FETCH selects visible, every enable held low
      rst = 1'b1;
      bus.op = 7'd0;
      bus.mem_ready = 1'b1;
      @(posedge clk);
      #1;
      check("reset_c1", observed(), V_F);
      @(posedge clk);
      #1;
      check("reset_c2", observed(), V_F);
      rst = 1'b0;

      // Directed instruction sequences
      run_instr(OP_LW, 0, 0);
      run_instr(OP_SW, 0, 3);
      run_instr(OP_BEQ, 0, 0);
      run_instr(OP_JAL, 0, 0);
      run_instr(OP_R, 1, 0);
      run_instr(OP_I, 2, 0);
      run_instr(7'b0110111, 0, 0);
      // Watchdog: abort on the 4th idle cycle, ready on that cycle wins
      run_instr(OP_LW, 0, TO);
      run_instr(OP_LW, 0, TO - 1);
      run_instr(OP_SW, 0, TO + 1);
      run_instr(OP_R, TO, 0);
      run_instr(OP_BEQ, TO - 1, 0);

      // Reset in the middle of a stalled store
      bus.op = OP_SW;
      cyc("rst_fetch", 1'b1, V_F | E_PCU | E_IRW);
      cyc("rst_decode", 1'b0, V_D);
      cyc("rst_memadr", 1'b0, V_MA);
      cyc("rst_memwrite", 1'b0, V_MW);
      rst = 1'b1;
      cyc("rst_in_memwrite", 1'b0, V_MW & ~ENABLES);
      rst = 1'b0;
      cyc("rst_then_fetch", 1'b0, V_F);
      run_instr(OP_I, 2, 0);

      // Randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         rnd = $urandom();
         if (rnd[3:0] == 4'd0) begin
            op = rnd[10:4];
         end else begin
            op = legal_ops[rnd[18:16] % 6];
         end
         run_instr(op, pick_waits(), pick_waits());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
